// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Turns a raster-order pixel stream into 3x3 neighbourhoods for the median
// sorter. The two previous lines live in line buffers, and a 3x3 shift
// register supplies the window. One window is emitted for each interior
// pixel, with no border padding. Frames may stream back-to-back.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   Valid_IN    qualifies DATA_IN (pixel accepted on a clk edge with Valid_IN=1)
//   DATA_IN     pixel, raster order, columns fastest
//   window_out  packed window; slice 3*i+j = pixel (r-2+i, c-2+j)
//   Valid_OUT   window_out/center_row/center_col valid this cycle
//   center_row  row of the window centre
//   center_col  column of the window centre
//   frame_done  one-cycle pulse with the last window of a frame
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW        = 256,
  parameter int COL        = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Valid_IN,
  input  logic [DATA_WIDTH-1:0]     DATA_IN,
  output logic [9*DATA_WIDTH-1:0]   window_out,
  output logic                      Valid_OUT,
  output logic [$clog2(ROW)-1:0]    center_row,
  output logic [$clog2(COL)-1:0]    center_col,
  output logic                      frame_done
);

  localparam int RW = $clog2(ROW);
  localparam int CW = $clog2(COL);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);

  logic [RW-1:0]           r_row_cnt;
  logic [CW-1:0]           r_col_cnt;
  logic [DATA_WIDTH-1:0]   r_lb0 [COL];
  logic [DATA_WIDTH-1:0]   r_lb1 [COL];
  logic [DATA_WIDTH-1:0]   r_sh  [9];

  logic [DATA_WIDTH-1:0]   w_lb0_rd;
  logic [DATA_WIDTH-1:0]   w_lb1_rd;
  logic [DATA_WIDTH-1:0]   w_sh_next [9];
  logic [9*DATA_WIDTH-1:0] w_win_packed;
  logic                    w_col_last;
  logic                    w_row_last;
  logic                    w_emit;

  // lb1 holds line r-1 and lb0 holds line r-2 at the current column.
  assign w_lb0_rd   = r_lb0[r_col_cnt];
  assign w_lb1_rd   = r_lb1[r_col_cnt];
  assign w_col_last = (r_col_cnt == COL_LAST);
  assign w_row_last = (r_row_cnt == ROW_LAST);
  // Gating on r>=2, c>=2 keeps windows from spanning a line or frame boundary.
  assign w_emit     = Valid_IN && (r_row_cnt >= RW'(2)) && (r_col_cnt >= CW'(2));

  always_comb begin
    for (int k = 0; k < 9; k++) w_sh_next[k] = r_sh[k];
    for (int i = 0; i < 3; i++) begin
      w_sh_next[3*i]   = r_sh[3*i+1];
      w_sh_next[3*i+1] = r_sh[3*i+2];
    end
    w_sh_next[2] = w_lb0_rd;
    w_sh_next[5] = w_lb1_rd;
    w_sh_next[8] = DATA_IN;
  end

  always_comb begin
    w_win_packed = '0;
    for (int k = 0; k < 9; k++) w_win_packed[DATA_WIDTH*k +: DATA_WIDTH] = w_sh_next[k];
  end

  // Line buffers carry no reset so they can map onto RAM; the read-before-write
  // at the same address moves line r-1 into lb0 as line r enters lb1.
  always_ff @(posedge clk) begin
    if (!reset && Valid_IN) begin
      r_lb1[r_col_cnt] <= DATA_IN;
      r_lb0[r_col_cnt] <= w_lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt  <= '0;
      r_col_cnt  <= '0;
      for (int k = 0; k < 9; k++) r_sh[k] <= '0;
      window_out <= '0;
      Valid_OUT  <= 1'b0;
      center_row <= '0;
      center_col <= '0;
      frame_done <= 1'b0;
    end else begin
      Valid_OUT  <= w_emit;
      frame_done <= Valid_IN && w_row_last && w_col_last;
      if (Valid_IN) begin
        for (int k = 0; k < 9; k++) r_sh[k] <= w_sh_next[k];
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
      end
      // The output register is loaded only for real windows. This keeps the
      // outputs held while edge pixels still shift through r_sh.
      if (w_emit) begin
        window_out <= w_win_packed;
        center_row <= r_row_cnt - RW'(1);
        center_col <= r_col_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;
  localparam int R = 5;
  localparam int C = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance (5x6)
  logic        reset, Valid_IN, Valid_OUT, frame_done;
  logic [7:0]  DATA_IN;
  logic [71:0] window_out;
  logic [2:0]  center_row, center_col;

  // default-size instance (256x256)
  logic        b_reset, b_valid, b_vout, b_fd;
  logic [7:0]  b_data;
  logic [71:0] b_win;
  logic [7:0]  b_crow, b_ccol;

  window_gen_3x3 #(.DATA_WIDTH(8), .ROW(R), .COL(C)) u_dut (
    .clk(clk), .reset(reset), .Valid_IN(Valid_IN), .DATA_IN(DATA_IN),
    .window_out(window_out), .Valid_OUT(Valid_OUT),
    .center_row(center_row), .center_col(center_col), .frame_done(frame_done));

  window_gen_3x3 u_big (
    .clk(clk), .reset(b_reset), .Valid_IN(b_valid), .DATA_IN(b_data),
    .window_out(b_win), .Valid_OUT(b_vout),
    .center_row(b_crow), .center_col(b_ccol), .frame_done(b_fd));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [71:0] pack_win(input int base);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(base + C*i + j);
    return w;
  endfunction

  // ---------------- small-instance model and scoreboard ----------------
  typedef struct {
    logic [71:0] win;
    logic [2:0]  cr;
    logic [2:0]  cc;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t        sq[$];
  logic [7:0]  img [R][C];
  int          m_r = 0, m_c = 0;
  int          nwin, nfd;
  logic [71:0] last_win;
  logic [5:0]  last_cent;
  logic [71:0] first_win, win12;
  logic [5:0]  first_cent;
  exp_t        me;

  task automatic drive(input logic v, input logic [7:0] d);
    exp_t e;
    @(posedge clk); #1;
    Valid_IN = v;
    DATA_IN  = d;
    if (v) begin
      img[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        e.win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[8*(3*i+j) +: 8] = img[m_r-2+i][m_c-2+j];
        e.cr  = 3'(m_r - 1);
        e.cc  = 3'(m_c - 1);
        e.fd  = (m_r == R-1) && (m_c == C-1);
        e.cyc = cyc + 1;
        sq.push_back(e);
      end
      if (m_c == C-1) begin
        m_c = 0;
        m_r = (m_r == R-1) ? 0 : m_r + 1;
      end else begin
        m_c++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    Valid_IN = 1'b1;
    DATA_IN  = 8'hAA;
    sq.delete();
    m_r = 0;
    m_c = 0;
    repeat (n) @(posedge clk);
    #1;
    reset    = 1'b0;
    Valid_IN = 1'b0;
  endtask

  task automatic start_phase();
    nwin = 0;
    nfd  = 0;
  endtask

  task automatic end_phase(input string tag, input int exp_win, input int exp_fd);
    repeat (3) drive(1'b0, 8'h00);
    check_eq({tag, "_nwin"}, nwin, exp_win);
    check_eq({tag, "_nfd"}, nfd, exp_fd);
    check_eq({tag, "_qempty"}, sq.size(), 0);
  endtask

  task automatic frame_checks(input string tag);
    check_eq({tag, "_first"}, first_win, pack_win(0));
    check_eq({tag, "_first_c"}, first_cent, {3'd1, 3'd1});
    check_eq({tag, "_last"}, last_win, pack_win(15));
    check_eq({tag, "_last_c"}, last_cent, {3'd3, 3'd4});
  endtask

  // ---------------- default-size model ----------------
  logic [7:0]  bimg [256][256];
  logic [23:0] bq[$];
  int          b_nwin = 0, b_nfd = 0;
  logic [15:0] b_first_c, b_last_c;
  logic [23:0] be;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_q === 1'b1) begin
      check_eq("rst_vout", Valid_OUT, 1'b0);
      check_eq("rst_fd", frame_done, 1'b0);
      check_eq("rst_win", window_out, 72'h0);
      check_eq("rst_cent", {center_row, center_col}, 6'h0);
      last_win  = '0;
      last_cent = '0;
    end else if (Valid_OUT === 1'b1) begin
      if (sq.size() == 0) begin
        check_eq("spurious_win", 1'b1, 1'b0);
      end else begin
        me = sq.pop_front();
        check_eq("win", window_out, me.win);
        check_eq("cent", {center_row, center_col}, {me.cr, me.cc});
        check_eq("fd", frame_done, me.fd);
        check_eq("latency", cyc, me.cyc);
      end
      if (nwin == 0) begin
        first_win  = window_out;
        first_cent = {center_row, center_col};
      end
      if (nwin == 12) win12 = window_out;
      nwin++;
      if (frame_done) nfd++;
      last_win  = window_out;
      last_cent = {center_row, center_col};
    end else begin
      check_eq("idle_vout", Valid_OUT, 1'b0);
      check_eq("idle_fd", frame_done, 1'b0);
      check_eq("hold", {window_out, center_row, center_col}, {last_win, last_cent});
    end

    if (b_reset === 1'b0 && b_vout === 1'b1) begin
      if (bq.size() == 0) begin
        check_eq("big_spurious", 1'b1, 1'b0);
      end else begin
        be = bq.pop_front();
        check_eq("big_win", {b_win[39:32], b_crow, b_ccol}, be);
      end
      if (b_nwin == 0) b_first_c = {b_crow, b_ccol};
      b_last_c = {b_crow, b_ccol};
      b_nwin++;
      if (b_fd) b_nfd++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    b_reset = 1'b1;
    b_valid = 1'b0;
    b_data  = '0;

    fork
      begin : small_tests
        int p, tries;
        do_reset(2);

        // continuous frame
        start_phase();
        for (int q = 0; q < 30; q++) drive(1'b1, 8'(q));
        end_phase("cont", 12, 1);
        frame_checks("cont");

        // gapped frame
        start_phase();
        p = 0;
        tries = 0;
        while (p < 30 && tries < 1000) begin
          if ($urandom_range(0, 1) == 1) begin
            drive(1'b1, 8'(p));
            p++;
          end else begin
            drive(1'b0, 8'($urandom));
          end
          tries++;
        end
        check_eq("gap_bound", tries < 1000, 1'b1);
        end_phase("gap", 12, 1);
        frame_checks("gap");

        // back-to-back frames
        start_phase();
        for (int q = 0; q < 60; q++) drive(1'b1, (q < 30) ? 8'(q) : 8'(q - 30 + 100));
        end_phase("b2b", 24, 2);
        check_eq("b2b_f2_first", win12, pack_win(100));

        // mid-frame reset
        for (int q = 0; q < 17; q++) drive(1'b1, 8'(q + 50));
        repeat (2) drive(1'b0, 8'h00);
        do_reset(1);
        drive(1'b0, 8'h00);
        start_phase();
        for (int q = 0; q < 30; q++) drive(1'b1, 8'(q));
        end_phase("midrst", 12, 1);
        frame_checks("midrst");
      end

      begin : big_test
        int br, bc;
        logic [7:0] d;
        repeat (2) @(posedge clk);
        #1 b_reset = 1'b0;
        br = 0;
        bc = 0;
        for (int q = 0; q < 65536; q++) begin
          @(posedge clk); #1;
          d = 8'($urandom);
          b_valid = 1'b1;
          b_data  = d;
          bimg[br][bc] = d;
          if (br >= 2 && bc >= 2) bq.push_back({bimg[br-1][bc-1], 8'(br - 1), 8'(bc - 1)});
          if (bc == 255) begin
            bc = 0;
            br = (br == 255) ? 0 : br + 1;
          end else begin
            bc++;
          end
        end
        @(posedge clk); #1 b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("big_nwin", b_nwin, 64516);
        check_eq("big_nfd", b_nfd, 1);
        check_eq("big_first_c", b_first_c, {8'd1, 8'd1});
        check_eq("big_last_c", b_last_c, {8'd254, 8'd254});
        check_eq("big_qempty", bq.size(), 0);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
